// File: rtl/poly_root_search.sv
// poly_root_search
//   Operator-driven brute-force search for the smallest 8-bit x satisfying
//   A*x + B*x^2 + C == Y (mod 256). Operands A, B, C, Y are entered one at a
//   time from data_in, each latched by a press/release of go. The search
//   evaluates one candidate every six cycles through a single shared 8-bit
//   add/multiply unit.
// Ports:
//   clk      - rising-edge clock
//   resetn   - asynchronous active-low reset
//   go       - operator strobe (held many cycles per press)
//   data_in  - operand source for A, B, C, Y
//   x_result - smallest root found, 0 when none
//   found    - x_result holds a valid root
//   done     - high while in S_DONE
//   busy     - high while evaluating candidates
module poly_root_search (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic [7:0] data_in,
  output logic [7:0] x_result,
  output logic       found,
  output logic       done,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_LOAD_A, S_LOAD_A_WAIT,
    S_LOAD_B, S_LOAD_B_WAIT,
    S_LOAD_C, S_LOAD_C_WAIT,
    S_LOAD_Y, S_LOAD_Y_WAIT,
    S_EVAL_0, S_EVAL_1, S_EVAL_2, S_EVAL_3, S_EVAL_4, S_EVAL_5,
    S_DONE
  } state_t;

  state_t     state, next_state;
  logic [7:0] a_q, b_q, c_q, y_q, x_q, t_q, s_q;
  logic [7:0] alu_a, alu_b, alu_res;
  logic       alu_mul;
  logic       match;
  // In S_DONE a press counts only after go has been seen low (armed) and then
  // high (pressed); a press still held from before entry is thereby ignored.
  logic       armed, pressed;

  assign match = (t_q == y_q);

  // Shared ALU: operand selection depends only on the evaluation step.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_mul = 1'b0;
    case (state)
      S_EVAL_0: begin alu_a = a_q; alu_b = x_q; alu_mul = 1'b1; end
      S_EVAL_1: begin alu_a = x_q; alu_b = x_q; alu_mul = 1'b1; end
      S_EVAL_2: begin alu_a = b_q; alu_b = s_q; alu_mul = 1'b1; end
      S_EVAL_3: begin alu_a = t_q; alu_b = s_q; end
      S_EVAL_4: begin alu_a = t_q; alu_b = c_q; end
      default: ;
    endcase
    alu_res = alu_mul ? (alu_a * alu_b) : (alu_a + alu_b);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_LOAD_A:      if (go)  next_state = S_LOAD_A_WAIT;
      S_LOAD_A_WAIT: if (!go) next_state = S_LOAD_B;
      S_LOAD_B:      if (go)  next_state = S_LOAD_B_WAIT;
      S_LOAD_B_WAIT: if (!go) next_state = S_LOAD_C;
      S_LOAD_C:      if (go)  next_state = S_LOAD_C_WAIT;
      S_LOAD_C_WAIT: if (!go) next_state = S_LOAD_Y;
      S_LOAD_Y:      if (go)  next_state = S_LOAD_Y_WAIT;
      S_LOAD_Y_WAIT: if (!go) next_state = S_EVAL_0;
      S_EVAL_0:      next_state = S_EVAL_1;
      S_EVAL_1:      next_state = S_EVAL_2;
      S_EVAL_2:      next_state = S_EVAL_3;
      S_EVAL_3:      next_state = S_EVAL_4;
      S_EVAL_4:      next_state = S_EVAL_5;
      S_EVAL_5:      next_state = (match || x_q == 8'hFF) ? S_DONE : S_EVAL_0;
      S_DONE:        if (armed && pressed && !go) next_state = S_LOAD_A;
      default:       next_state = S_LOAD_A;
    endcase
  end

  // busy/done are registered from next_state so they track state exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_LOAD_A;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state inside {S_EVAL_0, S_EVAL_1, S_EVAL_2,
                                   S_EVAL_3, S_EVAL_4, S_EVAL_5});
      done  <= (next_state == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      y_q      <= '0;
      x_q      <= '0;
      t_q      <= '0;
      s_q      <= '0;
      x_result <= '0;
      found    <= 1'b0;
      armed    <= 1'b0;
      pressed  <= 1'b0;
    end else begin
      case (state)
        S_LOAD_A:      a_q <= data_in;
        S_LOAD_B:      b_q <= data_in;
        S_LOAD_C:      c_q <= data_in;
        S_LOAD_Y:      y_q <= data_in;
        S_LOAD_Y_WAIT: if (!go) x_q <= '0;
        S_EVAL_0, S_EVAL_3, S_EVAL_4: t_q <= alu_res;
        S_EVAL_1, S_EVAL_2:           s_q <= alu_res;
        S_EVAL_5: begin
          armed   <= 1'b0;
          pressed <= 1'b0;
          if (match) begin
            x_result <= x_q;
            found    <= 1'b1;
          end else if (x_q == 8'hFF) begin
            x_result <= '0;
            found    <= 1'b0;
          end else begin
            x_q <= x_q + 8'd1;
          end
        end
        S_DONE: begin
          if (!go)          armed   <= 1'b1;
          if (armed && go)  pressed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_root_search.sv
// Scoreboard bench for poly_root_search: each loaded operand set pushes the
// reference-model root, found flag and search latency onto a queue;
// the entry is popped and compared when done rises.
module tb_poly_root_search;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] x_result;
  logic       found, done, busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] x;
    logic       f;
    int         lat;
  } exp_t;
  exp_t sb[$];

  logic [7:0] held_x;
  logic       held_f;

  poly_root_search dut (
    .clk(clk), .resetn(resetn), .go(go), .data_in(data_in),
    .x_result(x_result), .found(found), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] poly(input logic [7:0] a, b, c, xv);
    logic [7:0] sq, r;
    sq = xv * xv;
    r  = a * xv + b * sq + c;
    return r;
  endfunction

  function automatic exp_t model(input logic [7:0] a, b, c, y);
    exp_t e;
    e.x = '0; e.f = 1'b0; e.lat = 6 * 256;
    for (int unsigned k = 0; k < 256; k++) begin
      if (poly(a, b, c, k[7:0]) == y) begin
        e.x = k[7:0]; e.f = 1'b1; e.lat = 6 * (int'(k) + 1);
        break;
      end
    end
    return e;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enter A, B, C, Y with press/release each; optionally score the result.
  task automatic load_operands(input logic [7:0] a, b, c, y, input bit push);
    logic [7:0] ops [4];
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = y;
    for (int i = 0; i < 4; i++) begin
      data_in = ops[i];
      cycles(2);
      go = 1'b1;
      data_in = ops[i];
      cycles(3);
      data_in = 8'hA5;  // must not load while waiting for release
      go = 1'b0;
    end
    if (push) sb.push_back(model(a, b, c, y));
  endtask

  // Wait for done, counting busy cycles; optionally toggle go during search
  // and leave it held high on entry to S_DONE.
  task automatic check_search(input string name, input bit toggle_go);
    int   lat = 0, guard = 0;
    bit   dropped = 0;
    exp_t e;
    while (!done && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (busy) lat++;
      else if (lat > 0 && !done) dropped = 1;
      if (toggle_go) go = $urandom_range(0, 1);
    end
    if (toggle_go) go = 1'b1;
    e = sb.pop_front();
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s timeout: done=%b required 1 within 2000 cycles", name, done);
    end
    vectors++;
    if (x_result !== e.x) begin
      miscompares++;
      $display("FAIL %s x_result: got %0d required %0d", name, x_result, e.x);
    end
    vectors++;
    if (found !== e.f) begin
      miscompares++;
      $display("FAIL %s found: got %b required %b", name, found, e.f);
    end
    vectors++;
    if (lat != e.lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
    end
    vectors++;
    if (busy !== 1'b0 || dropped) begin
      miscompares++;
      $display("FAIL %s busy: at done %b dropped %b required 0/0", name, busy, dropped);
    end
    held_x = e.x;
    held_f = e.f;
  endtask

  // Press/release in S_DONE; result must persist into the load phase.
  task automatic return_to_load(input string name);
    go = 1'b0;
    cycles(2);
    go = 1'b1;
    cycles(3);
    go = 1'b0;
    cycles(3);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: done=%b busy=%b required 0 0", name, done, busy);
    end
    vectors++;
    if (x_result !== held_x || found !== held_f) begin
      miscompares++;
      $display("FAIL %s hold: x_result=%0d found=%b required %0d %b",
               name, x_result, found, held_x, held_f);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cycles(3);
    vectors++;
    if ({x_result, found, done, busy} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset: outputs %h required 0", {x_result, found, done, busy});
    end
    resetn = 1'b1;
    cycles(1);
  endtask

  task automatic test_basic();
    load_operands(8'd2, 8'd1, 8'd3, 8'd11, 1);
    check_search("basic", 0);
    return_to_load("basic");
  endtask

  task automatic test_wrap();
    load_operands(8'd1, 8'd0, 8'd250, 8'd4, 1);
    check_search("wrap", 0);
    return_to_load("wrap");
  endtask

  task automatic test_no_solution();
    load_operands(8'd0, 8'd0, 8'd5, 8'd7, 1);
    check_search("nosol", 0);
    return_to_load("nosol");
  endtask

  task automatic test_multi_root();
    load_operands(8'd0, 8'd1, 8'd0, 8'd0, 1);
    check_search("multiroot", 0);
    return_to_load("multiroot");
  endtask

  task automatic test_go_ignored();
    load_operands(8'd3, 8'd2, 8'd7, 8'd200, 1);
    check_search("goignored", 1);
    cycles(5);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL held_press: done=%b required 1", done);
    end
    go = 1'b0;
    cycles(3);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL stale_release: done=%b required 1", done);
    end
    return_to_load("goignored");
  endtask

  task automatic test_reset_mid_search();
    int n = 0, guard = 0;
    load_operands(8'd0, 8'd0, 8'd5, 8'd7, 0);
    while (n < 100 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (busy) n++;
    end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if ({x_result, found, done, busy} !== 11'd0 || n != 100) begin
      miscompares++;
      $display("FAIL midreset: outputs %h evalcycles %0d required 0 100",
               {x_result, found, done, busy}, n);
    end
    cycles(2);
    resetn = 1'b1;
    load_operands(8'd2, 8'd1, 8'd3, 8'd11, 1);
    check_search("afterreset", 0);
    return_to_load("afterreset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, c, xr;
    for (int i = 0; i < 4; i++) begin
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      c  = $urandom_range(0, 255);
      xr = $urandom_range(0, 60);
      load_operands(a, b, c, poly(a, b, c, xr), 1);
      check_search("random", 0);
      return_to_load("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_search();
    test_wrap();
    test_no_solution();
    test_multi_root();
    test_go_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/poly_root_search.md
POLY_ROOT_SEARCH -- requirements
Module: poly_root_search

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are clk and resetn.
REQ-002 clk  input  1  rising-edge system clock; all state changes on its rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset; forces reset state immediately, independent of clk.
REQ-004 go  input  1  active-high operator strobe (inverted KEY at top level), synchronous to clk, held many cycles per press.
REQ-005 data_in  input  8  unsigned operand source for A, B, C, Y.
REQ-006 x_result  output  8  registered smallest x with A*x + B*x^2 + C == Y (mod 256); 0 when none found.
REQ-007 found  output  1  registered; 1 = x_result valid solution.
REQ-008 done  output  1  registered; 1 while the block is in S_DONE.
REQ-009 busy  output  1  registered; 1 while the block is in any S_EVAL_* state.

Function
REQ-010 States SHALL be: S_LOAD_A, S_LOAD_A_WAIT, S_LOAD_B, S_LOAD_B_WAIT, S_LOAD_C, S_LOAD_C_WAIT, S_LOAD_Y, S_LOAD_Y_WAIT, S_EVAL_0..S_EVAL_5, S_DONE.
REQ-011 In S_LOAD_n the register n SHALL load data_in every cycle; go=1 -> S_LOAD_n_WAIT, else stay.
REQ-012 In S_LOAD_n_WAIT no register loads; go=0 -> next load state (A->B->C->Y), S_LOAD_Y_WAIT -> S_EVAL_0 with x counter = 0.
REQ-013 One shared 8-bit ALU (add/multiply) SHALL be used; all results truncated to 8 bits (mod 256).
REQ-014 Per-candidate sequence, one cycle each: EVAL_0 t=A*x; EVAL_1 s=x*x; EVAL_2 s=B*s; EVAL_3 t=t+s; EVAL_4 t=t+C; EVAL_5 compare t with Y.
REQ-015 EVAL_5 with t==Y SHALL register x_result=x, found=1, go to S_DONE.
REQ-016 EVAL_5 with t!=Y and x==255 SHALL register x_result=0, found=0, go to S_DONE; x SHALL never wrap to 0 and re-search.
REQ-017 EVAL_5 with t!=Y and x<255 SHALL increment x and return to EVAL_0.
REQ-018 Latency: S_DONE entered exactly 6*(k+1) cycles after entry to S_EVAL_0, k = winning x (k=255 for no-solution, 1536 cycles).
REQ-019 go SHALL be ignored in all S_EVAL_* states; A, B, C, Y SHALL not change during search.
REQ-020 In S_DONE x_result and found SHALL hold; go=1 then go=0 (press and release) SHALL return to S_LOAD_A; if go is still high on entry to S_DONE, that press SHALL not count.
REQ-021 x_result and found SHALL retain their values through the next load phase until the next EVAL_5 decision.
REQ-022 busy=1 exactly in S_EVAL_*; done=1 exactly in S_DONE; both 0 in load states.

Reset
REQ-023 resetn=0 SHALL immediately set state=S_LOAD_A and A, B, C, Y, x, t, s, x_result=0, found=0, done=0, busy=0.
REQ-024 Reset asserted mid-search or in S_DONE SHALL abort with no partial result; the first cycle after deassertion is S_LOAD_A.

Verification
REQ-025 A=2,B=1,C=3,Y=11 -> found=1, x_result=2, done rises 18 cycles after S_EVAL_0 entry.
REQ-026 A=1,B=0,C=250,Y=4 (mod-256 wrap) -> found=1, x_result=10, done after 66 cycles.
REQ-027 A=0,B=0,C=5,Y=7 -> found=0, x_result=0, done after 1536 cycles, busy high throughout search.
REQ-028 A=0,B=1,C=0,Y=0 -> x_result=0, found=1 after 6 cycles; multiple roots (0,16,...) yield smallest.
REQ-029 go toggled during search -> ignored, result unchanged; then in S_DONE press/release -> back to S_LOAD_A, x_result held until next decision.
REQ-030 resetn pulsed low at EVAL cycle 100 -> all outputs 0 asynchronously, state S_LOAD_A, new full load sequence succeeds.
